// File: rtl/datamemory_ctrl.sv
// rtl/datamemory_ctrl.sv - RISC-V MEM-stage data memory with lane masks, load extension and sticky fault trap
module datamemory_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              fault_valid,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              fault_store,
    input  logic              fault_clr
);
    localparam int  NB    = DATA_W / 8;
    localparam int  OFS   = $clog2(NB);
    localparam int  DEPTH = 2 ** (ADDR_W - OFS);
    localparam bit  IS64  = (DATA_W == 64);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]            size;
    logic                  zext;
    logic [OFS-1:0]        lane;
    logic [ADDR_W-OFS-1:0] idx;
    logic                  legal;
    logic                  misaligned;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic                  fault_event;
    logic [7:0]            base_mask;
    logic [NB-1:0]         lane_mask;
    logic [DATA_W-1:0]     wdata_sh;
    logic [DATA_W-1:0]     rd_sh;
    logic [DATA_W-1:0]     low_mask;
    logic                  sign_bit;
    logic [DATA_W-1:0]     ld_ext;

    assign size = req_funct3[1:0];
    assign zext = req_funct3[2];
    assign lane = req_addr[OFS-1:0];
    assign idx  = req_addr[ADDR_W-1:OFS];

    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = IS64;
                default:                legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = IS64;
                default:                                legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign accept      = req_valid && legal && !misaligned;
    assign wr_en       = accept && req_we;
    assign rd_en       = accept && !req_we;
    assign fault_event = req_valid && !(legal && !misaligned);

    always_comb begin
        case (size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        lane_mask = base_mask[NB-1:0] << lane;
        wdata_sh  = req_wdata << {lane, 3'b000};
    end

    // Byte-enable write: unmasked lanes keep their contents without a read cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (lane_mask[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_sh = mem[idx] >> {lane, 3'b000};
        case (size)
            2'd0: begin low_mask = {DATA_W{1'b1}} >> (DATA_W - 8);  sign_bit = rd_sh[7];  end
            2'd1: begin low_mask = {DATA_W{1'b1}} >> (DATA_W - 16); sign_bit = rd_sh[15]; end
            2'd2: begin low_mask = {DATA_W{1'b1}} >> (DATA_W - 32); sign_bit = rd_sh[31]; end
            default: begin low_mask = {DATA_W{1'b1}}; sign_bit = 1'b0; end
        endcase
        ld_ext = rd_sh & low_mask;
        if (sign_bit && !zext) ld_ext = ld_ext | ~low_mask;
    end

    // Stage 1 holds the extended read; later stages only delay it.
    logic [RD_LAT-1:0] v_pipe;
    logic [DATA_W-1:0] d_pipe [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) d_pipe[i] <= '0;
        end else begin
            v_pipe[0] <= rd_en;
            if (rd_en) d_pipe[0] <= ld_ext;
            for (int i = 1; i < RD_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                if (v_pipe[i-1]) d_pipe[i] <= d_pipe[i-1];
            end
        end
    end

    assign rsp_valid = v_pipe[RD_LAT-1];
    assign rsp_rdata = d_pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
            fault_store <= 1'b0;
        end else if (fault_event && (!fault_valid || fault_clr)) begin
            fault_valid <= 1'b1;
            fault_addr  <= req_addr;
            fault_store <= req_we;
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
        end
    end

`ifdef DATAMEMORY_CTRL_TRACE
    always @(posedge clk) begin
        if (wr_en)
            $display("Write value: [%X] | [%b] on address [%X]", req_wdata, req_wdata, req_addr);
        if (rsp_valid)
            $display("Read value: [%X] | [%b]", rsp_rdata, rsp_rdata);
    end
`endif

endmodule

// File: tb/tb_datamemory_ctrl.sv
// tb/tb_datamemory_ctrl.sv - directed self-checking bench for datamemory_ctrl (32-bit/lat 1 and 64-bit/lat 3)
module tb_datamemory_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_req_valid, a_req_we, a_fault_clr;
    logic [2:0]  a_funct3;
    logic [10:0] a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        a_rsp_valid, a_fault_valid, a_fault_store;
    logic [10:0] a_fault_addr;

    logic        b_reset, b_req_valid, b_req_we, b_fault_clr;
    logic [2:0]  b_funct3;
    logic [10:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic        b_rsp_valid, b_fault_valid, b_fault_store;
    logic [10:0] b_fault_addr;

    datamemory_ctrl #(.DATA_W(32), .ADDR_W(11), .RD_LAT(1)) u_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_we(a_req_we),
        .req_funct3(a_funct3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .fault_valid(a_fault_valid),
        .fault_addr(a_fault_addr), .fault_store(a_fault_store), .fault_clr(a_fault_clr)
    );

    datamemory_ctrl #(.DATA_W(64), .ADDR_W(11), .RD_LAT(3)) u_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_we(b_req_we),
        .req_funct3(b_funct3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .fault_valid(b_fault_valid),
        .fault_addr(b_fault_addr), .fault_store(b_fault_store), .fault_clr(b_fault_clr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic we, input logic [2:0] f3, input logic [10:0] addr, input logic [31:0] wd);
        a_req_valid = 1'b1; a_req_we = we; a_funct3 = f3; a_addr = addr; a_wdata = wd;
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic b_req(input logic we, input logic [2:0] f3, input logic [10:0] addr, input logic [63:0] wd);
        b_req_valid = 1'b1; b_req_we = we; b_funct3 = f3; b_addr = addr; b_wdata = wd;
        step();
        b_req_valid = 1'b0;
    endtask

    initial begin
        a_reset = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_fault_clr = 1'b0;
        a_funct3 = 3'd0; a_addr = '0; a_wdata = '0;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_fault_clr = 1'b0;
        b_funct3 = 3'd0; b_addr = '0; b_wdata = '0;
        step(); step();
        chk("a_reset_rsp_valid", a_rsp_valid, 0);
        chk("a_reset_rsp_rdata", a_rdata, 0);
        chk("a_reset_fault_valid", a_fault_valid, 0);
        chk("a_reset_fault_addr", a_fault_addr, 0);
        chk("a_reset_fault_store", a_fault_store, 0);
        a_reset = 1'b0; b_reset = 1'b0;
        step();

        // 32-bit, latency 1: extension cases
        a_req(1'b1, 3'b010, 11'h010, 32'hDEADBEEF);
        chk("a_sw_no_rsp", a_rsp_valid, 0);
        a_req(1'b0, 3'b000, 11'h013, '0);
        chk("a_lb_valid", a_rsp_valid, 1);
        chk("a_lb_data", a_rdata, 64'hFFFFFFDE);
        a_req(1'b0, 3'b100, 11'h013, '0);
        chk("a_lbu_valid", a_rsp_valid, 1);
        chk("a_lbu_data", a_rdata, 64'h000000DE);
        a_req(1'b0, 3'b001, 11'h012, '0);
        chk("a_lh_data", a_rdata, 64'hFFFFDEAD);
        a_req(1'b0, 3'b101, 11'h010, '0);
        chk("a_lhu_valid", a_rsp_valid, 1);
        chk("a_lhu_data", a_rdata, 64'h0000BEEF);
        step();
        chk("a_rsp_drop", a_rsp_valid, 0);
        chk("a_rdata_hold", a_rdata, 64'h0000BEEF);

        // Byte/half merge into a word, load right after the last store
        a_req(1'b1, 3'b010, 11'h020, 32'h11223344);
        a_req(1'b1, 3'b000, 11'h021, 32'h000000AA);
        a_req(1'b1, 3'b001, 11'h022, 32'h00005566);
        a_req(1'b0, 3'b010, 11'h020, '0);
        chk("a_merge_valid", a_rsp_valid, 1);
        chk("a_merge_data", a_rdata, 64'h5566AA44);

        // Fault handling
        a_req(1'b1, 3'b010, 11'h000, 32'h01234567);
        a_req(1'b0, 3'b010, 11'h006, '0);
        chk("a_mis_no_rsp", a_rsp_valid, 0);
        chk("a_mis_fault_valid", a_fault_valid, 1);
        chk("a_mis_fault_addr", a_fault_addr, 11'h006);
        chk("a_mis_fault_store", a_fault_store, 0);
        a_req(1'b1, 3'b001, 11'h001, 32'h0000FFFF);
        chk("a_sticky_addr", a_fault_addr, 11'h006);
        chk("a_sticky_store", a_fault_store, 0);
        a_req(1'b0, 3'b010, 11'h000, '0);
        chk("a_word0_intact", a_rdata, 64'h01234567);
        a_fault_clr = 1'b1;
        step();
        a_fault_clr = 1'b0;
        chk("a_clr_fault_valid", a_fault_valid, 0);

        a_req(1'b1, 3'b011, 11'h020, 32'hFFFFFFFF);
        chk("a_sd32_fault_valid", a_fault_valid, 1);
        chk("a_sd32_fault_addr", a_fault_addr, 11'h020);
        chk("a_sd32_fault_store", a_fault_store, 1);
        a_req(1'b0, 3'b010, 11'h020, '0);
        chk("a_sd32_mem_unchanged", a_rdata, 64'h5566AA44);

        a_fault_clr = 1'b1;
        a_req(1'b0, 3'b010, 11'h002, '0);
        a_fault_clr = 1'b0;
        chk("a_setwins_valid", a_fault_valid, 1);
        chk("a_setwins_addr", a_fault_addr, 11'h002);
        chk("a_setwins_store", a_fault_store, 0);

        // 64-bit, latency 3, back-to-back loads
        b_req(1'b1, 3'b011, 11'h008, 64'h8000000000000001);
        b_req(1'b0, 3'b011, 11'h008, '0);
        b_req(1'b0, 3'b110, 11'h00C, '0);
        chk("b_lat_not_early", b_rsp_valid, 0);
        b_req(1'b0, 3'b010, 11'h00C, '0);
        chk("b_ld_valid", b_rsp_valid, 1);
        chk("b_ld_data", b_rdata, 64'h8000000000000001);
        step();
        chk("b_lwu_valid", b_rsp_valid, 1);
        chk("b_lwu_data", b_rdata, 64'h0000000080000000);
        step();
        chk("b_lw_valid", b_rsp_valid, 1);
        chk("b_lw_data", b_rdata, 64'hFFFFFFFF80000000);
        step();
        chk("b_rsp_drop", b_rsp_valid, 0);

        // Reset while loads are in flight
        b_req(1'b0, 3'b000, 11'h008, '0);
        b_req(1'b0, 3'b000, 11'h008, '0);
        b_req(1'b0, 3'b000, 11'h008, '0);
        chk("b_first_inflight", b_rsp_valid, 1);
        chk("b_first_inflight_data", b_rdata, 64'h0000000000000001);
        b_reset = 1'b1;
        #1;
        chk("b_rst_rsp_valid", b_rsp_valid, 0);
        chk("b_rst_rdata", b_rdata, 0);
        chk("b_rst_fault_valid", b_fault_valid, 0);
        chk("b_rst_fault_addr", b_fault_addr, 0);
        chk("b_rst_fault_store", b_fault_store, 0);
        step();
        b_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b_flushed_rsp_valid", b_rsp_valid, 0);
        end
        b_req(1'b0, 3'b011, 11'h008, '0);
        step();
        chk("b_post_rst_not_early", b_rsp_valid, 0);
        step();
        chk("b_post_rst_valid", b_rsp_valid, 1);
        chk("b_post_rst_data", b_rdata, 64'h8000000000000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
